decode_in_stream_driver: RTL and testbench
==========================================

Name: decode_in_stream_driver

Overview:
- Parametrised, buffered successor to the decode-stage input driver.
- Accepts decode-input items (instr, npc, enable, hold length) over a valid/ready stream and queues them in an internal FIFO.
- Replays items onto the decode-stage inputs (enable_decode, instr_dout, npc_in), holding each item for a programmable number of cycles, back-to-back with no bubbles.
- Sits between the sequence/stimulus source and the LC3 decode-stage input pins.

Parameters:
INSTR_W, 16, width of instr_dout / in_instr
NPC_W, 16, width of npc_in / in_npc
DEPTH, 8, FIFO entries; power of 2, >= 2
HOLD_W, 4, width of per-item hold count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO and drive state
in_valid  in  1  item offered
in_ready  out  1  FIFO can accept (not full and not flush)
in_instr  in  INSTR_W  instruction of offered item
in_npc  in  NPC_W  next-PC of offered item
in_enable  in  1  enable_decode value for offered item
in_hold  in  HOLD_W  extra cycles to hold item (0 = one cycle)
enable_decode  out  1  registered decode enable
instr_dout  out  INSTR_W  registered instruction
npc_in  out  NPC_W  registered next-PC
count  out  $clog2(DEPTH)+1  FIFO occupancy
busy  out  1  state==ACTIVE or count!=0

Behaviour:
- Clock is clk; reset is asynchronous and active-high on rst.
- Reset (async, immediate):
  - enable_decode, instr_dout, npc_in = 0.
  - FIFO empty, count = 0, hold counter = 0, state IDLE.
  - in_ready = 1 and busy = 0 once rst deasserts.
- Push: occurs on an edge where in_valid && in_ready.
  - in_ready = (count < DEPTH) && !flush.
  - No full-bypass: when full, in_ready stays 0 even on a pop cycle.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - If FIFO non-empty, pop head on next edge, register its fields onto the outputs, load hold_cnt = item.hold, go ACTIVE.
  - Otherwise enable_decode = 0; instr_dout and npc_in keep their last values.
- ACTIVE:
  - While hold_cnt != 0, outputs held and hold_cnt decrements.
  - When hold_cnt == 0 and FIFO non-empty, pop next item on the same edge (back-to-back, no gap).
  - When hold_cnt == 0 and FIFO empty, go IDLE with enable_decode <= 0, instr_dout/npc_in retained.
- Each item is visible for exactly hold+1 cycles, so the maximum is 2^HOLD_W cycles.
- Latency: an item accepted into an empty, idle block at edge k appears on the outputs after edge k+1.
- Simultaneous push and pop: legal when not full; count unchanged.
- Flush:
  - On the next edge, FIFO is emptied, count = 0, outputs = 0, state IDLE.
  - Flush wins over a same-cycle push; in_ready is 0 while flush is high.
- Reset mid-hold: outputs drop to 0 immediately; the queued items are lost.
- The pointers wrap modulo DEPTH. count is the true occupancy, 0..DEPTH.
- All outputs are registered; no combinational path from in_* to the decode-side outputs.

Decomposition:
- Package decode_in_stream_pkg holds:
  - typedef struct packed decode_in_item_t {instr, npc, enable, hold} (widths from the package defaults).
  - typedef enum {IDLE, ACTIVE} drv_state_e.
- Sub-module decode_in_stream_fifo: synchronous parametrised FIFO (WIDTH, DEPTH) with push, pop, full, empty and count, plus async rst and sync flush.

Test Plan:
- Reset: pulse rst between clock edges during ACTIVE -> outputs 0 immediately without a clock edge; after release count=0, in_ready=1, busy=0.
- Single item: push instr=16'h1234, npc=16'h3001, enable=1, hold=0 at edge 1 -> after edge 2 outputs show 1234/3001/1 for exactly one cycle; after edge 3 enable_decode=0 and instr_dout stays 16'h1234.
- Back-to-back: push three items with hold=2 (instr 16'h1001/16'h1002/16'h1003) -> each visible exactly 3 cycles, contiguous 9 cycles, enable_decode never drops between items.
- Full: first item hold=15, then offer 9 more with DEPTH=8 -> after the first pops, count reaches 8 and in_ready=0, so exactly 8 are accepted; in_ready returns to 1 on the cycle after the next pop.
- Flush: assert flush with in_valid=1 while count=3 -> after the edge count=0, the push is dropped, outputs=0, state IDLE.
- Reset during hold: item hold=10 active, rst asserted at cycle 4 of the hold -> outputs 0 and FIFO empty; after release no residual item is driven.

Source files
------------

// File: rtl/decode_in_stream_driver_pkg.sv
// Shared types and default widths for the buffered decode-stage input driver.
// The packed item layout here is the one stored in the FIFO: {instr, npc, enable, hold}.
package decode_in_stream_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int NPC_W_DEF   = 16;
    localparam int HOLD_W_DEF  = 4;
    localparam int DEPTH_DEF   = 8;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [NPC_W_DEF-1:0]   npc;
        logic                   enable;
        logic [HOLD_W_DEF-1:0]  hold;
    } decode_in_item_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } drv_state_e;

    function automatic int item_width(input int instr_w, input int npc_w, input int hold_w);
        return instr_w + npc_w + 1 + hold_w;
    endfunction

endpackage

// File: rtl/decode_in_stream_driver_if.sv
// Valid/ready stream carrying one decode-input item from the stimulus source.
interface decode_in_stream_driver_if #(
    parameter int INSTR_W = 16,
    parameter int NPC_W   = 16,
    parameter int HOLD_W  = 4
) ();

    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [NPC_W-1:0]   npc;
    logic               enable;
    logic [HOLD_W-1:0]  hold;

    modport master (
        output valid,
        output instr,
        output npc,
        output enable,
        output hold,
        input  ready
    );

    modport slave (
        input  valid,
        input  instr,
        input  npc,
        input  enable,
        input  hold,
        output ready
    );

endinterface

// File: rtl/decode_in_stream_driver_fifo.sv
// Synchronous FIFO with async reset and sync flush; count reports true occupancy 0..DEPTH.
module decode_in_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/decode_in_stream_driver.sv
// Buffers decode-input items and replays each onto the LC3 decode-stage pins for hold+1 cycles,
// back-to-back with no bubbles between queued items.
module decode_in_stream_driver
    import decode_in_stream_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int NPC_W   = NPC_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int HOLD_W  = HOLD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    decode_in_stream_driver_if.slave in_if,
    output logic                     enable_decode,
    output logic [INSTR_W-1:0]       instr_dout,
    output logic [NPC_W-1:0]         npc_in,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int ITEM_W = item_width(INSTR_W, NPC_W, HOLD_W);

    drv_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                en_q, en_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [NPC_W-1:0]    npc_q, npc_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ITEM_W-1:0]   fifo_wdata;
    logic [ITEM_W-1:0]   fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                load_head;

    logic [INSTR_W-1:0]  head_instr;
    logic [NPC_W-1:0]    head_npc;
    logic                head_enable;
    logic [HOLD_W-1:0]   head_hold;

    // No full-bypass: a full FIFO refuses a push even on a pop cycle.
    assign in_if.ready = !fifo_full && !flush;
    assign fifo_push   = in_if.valid && in_if.ready;
    assign fifo_wdata  = {in_if.instr, in_if.npc, in_if.enable, in_if.hold};

    assign head_instr  = fifo_head[ITEM_W-1 -: INSTR_W];
    assign head_npc    = fifo_head[HOLD_W+1 +: NPC_W];
    assign head_enable = fifo_head[HOLD_W];
    assign head_hold   = fifo_head[HOLD_W-1:0];

    decode_in_stream_fifo #(
        .WIDTH (ITEM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A head is loaded on the same edge the previous item's hold expires, keeping items contiguous.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        en_d       = en_q;
        instr_d    = instr_q;
        npc_d      = npc_q;
        fifo_pop   = 1'b0;
        load_head  = 1'b0;

        if (flush) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            en_d       = 1'b0;
            instr_d    = '0;
            npc_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        load_head = 1'b1;
                    end else begin
                        en_d = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end else if (!fifo_empty) begin
                        load_head = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (load_head) begin
                fifo_pop   = 1'b1;
                state_d    = ACTIVE;
                hold_cnt_d = head_hold;
                en_d       = head_enable;
                instr_d    = head_instr;
                npc_d      = head_npc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            en_q       <= 1'b0;
            instr_q    <= '0;
            npc_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            en_q       <= en_d;
            instr_q    <= instr_d;
            npc_q      <= npc_d;
        end
    end

    assign enable_decode = en_q;
    assign instr_dout    = instr_q;
    assign npc_in        = npc_q;
    assign count         = fifo_count;
    assign busy          = (state_q == ACTIVE) || (fifo_count != '0);

endmodule

// File: tb/tb_decode_in_stream_driver.sv
// Directed bench for decode_in_stream_driver: a scoreboard queue holds one entry per expected
// enable_decode cycle and a negedge monitor pops and compares while the outputs are enabled.
module tb_decode_in_stream_driver;

    localparam int INSTR_W = 16;
    localparam int NPC_W   = 16;
    localparam int DEPTH   = 8;
    localparam int HOLD_W  = 4;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [NPC_W-1:0]   npc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 enable_decode;
    logic [INSTR_W-1:0]   instr_dout;
    logic [NPC_W-1:0]     npc_in;
    logic [$clog2(DEPTH):0] count;
    logic                 busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   waited;

    decode_in_stream_driver_if #(
        .INSTR_W (INSTR_W),
        .NPC_W   (NPC_W),
        .HOLD_W  (HOLD_W)
    ) sif ();

    decode_in_stream_driver #(
        .INSTR_W (INSTR_W),
        .NPC_W   (NPC_W),
        .DEPTH   (DEPTH),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_if         (sif),
        .enable_decode (enable_decode),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .count         (count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one item and waits (bounded) for the handshake; returns the number of edges waited.
    task automatic applyStimulus(input logic [INSTR_W-1:0] instr, input logic [NPC_W-1:0] npc,
                                 input logic [HOLD_W-1:0] hold, output int edges);
        logic accepted;
        accepted    = 1'b0;
        edges       = 0;
        sif.valid   = 1'b1;
        sif.instr   = instr;
        sif.npc     = npc;
        sif.enable  = 1'b1;
        sif.hold    = hold;
        while (!accepted && edges < 50) begin
            @(negedge clk);
            accepted = sif.ready;
            @(posedge clk);
            #1;
            edges++;
        end
        sif.valid = 1'b0;
        if (accepted) begin
            for (int i = 0; i <= int'(hold); i++) begin
                exp_q.push_back('{instr, npc});
            end
        end else begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL accept_timeout: item %h not accepted within %0d edges", instr, edges);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && enable_decode === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL sb_unexpected: got instr %h npc %h, expected no output", instr_dout, npc_in);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_instr", 32'(instr_dout), 32'(mon_e.instr));
                checkOutput("sb_npc", 32'(npc_in), 32'(mon_e.npc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        sif.valid  = 1'b0;
        sif.instr  = '0;
        sif.npc    = '0;
        sif.enable = 1'b0;
        sif.hold   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_enable", 32'(enable_decode), 32'd0);
        checkOutput("rst_instr", 32'(instr_dout), 32'd0);
        checkOutput("rst_npc", 32'(npc_in), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(sif.ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Single item, hold 0
        applyStimulus(16'h1234, 16'h3001, 4'd0, waited);
        checkOutput("single_wait", 32'(waited), 32'd1);
        checkOutput("single_count_queued", 32'(count), 32'd1);
        checkOutput("single_enable_pre", 32'(enable_decode), 32'd0);
        tick();
        checkOutput("single_enable", 32'(enable_decode), 32'd1);
        checkOutput("single_instr", 32'(instr_dout), 32'h1234);
        checkOutput("single_count_popped", 32'(count), 32'd0);
        tick();
        checkOutput("single_enable_drop", 32'(enable_decode), 32'd0);
        checkOutput("single_instr_kept", 32'(instr_dout), 32'h1234);
        checkOutput("single_npc_kept", 32'(npc_in), 32'h3001);
        checkOutput("single_busy_idle", 32'(busy), 32'd0);

        // Back-to-back, hold 2 each: nine contiguous enabled cycles
        applyStimulus(16'h1001, 16'h3010, 4'd2, waited);
        applyStimulus(16'h1002, 16'h3011, 4'd2, waited);
        applyStimulus(16'h1003, 16'h3012, 4'd2, waited);
        checkOutput("b2b_enable_c2", 32'(enable_decode), 32'd1);
        for (int c = 3; c <= 9; c++) begin
            tick();
            checkOutput($sformatf("b2b_enable_c%0d", c), 32'(enable_decode), 32'd1);
        end
        tick();
        checkOutput("b2b_enable_end", 32'(enable_decode), 32'd0);
        checkOutput("b2b_instr_kept", 32'(instr_dout), 32'h1003);

        // Full: long-held head, then eight fill the FIFO and the ninth waits
        applyStimulus(16'h2000, 16'h4000, 4'd15, waited);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'h2000 + 16'(i), 16'h4000 + 16'(i), 4'd0, waited);
        end
        checkOutput("full_count", 32'(count), 32'd8);
        checkOutput("full_in_ready", 32'(sif.ready), 32'd0);
        checkOutput("full_busy", 32'(busy), 32'd1);
        applyStimulus(16'h2009, 16'h4009, 4'd0, waited);
        checkOutput("full_ninth_wait", 32'(waited), 32'd10);
        checkOutput("full_count_after", 32'(count), 32'd7);
        repeat (10) tick();
        checkOutput("full_drained_busy", 32'(busy), 32'd0);
        checkOutput("full_drained_count", 32'(count), 32'd0);

        // Flush with count=3 and a same-cycle push
        applyStimulus(16'h3000, 16'h5000, 4'd15, waited);
        applyStimulus(16'h3001, 16'h5001, 4'd0, waited);
        applyStimulus(16'h3002, 16'h5002, 4'd0, waited);
        applyStimulus(16'h3003, 16'h5003, 4'd0, waited);
        checkOutput("flush_pre_count", 32'(count), 32'd3);
        flush      = 1'b1;
        sif.valid  = 1'b1;
        sif.instr  = 16'h4444;
        sif.npc    = 16'h6666;
        sif.enable = 1'b1;
        sif.hold   = 4'd0;
        #1;
        checkOutput("flush_in_ready", 32'(sif.ready), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        sif.valid = 1'b0;
        exp_q.delete();
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_enable", 32'(enable_decode), 32'd0);
        checkOutput("flush_instr", 32'(instr_dout), 32'd0);
        checkOutput("flush_npc", 32'(npc_in), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("flush_no_push_enable", 32'(enable_decode), 32'd0);
        checkOutput("flush_no_push_count", 32'(count), 32'd0);

        // Reset asserted between edges during a hold of 10
        applyStimulus(16'h5A5A, 16'h7000, 4'd10, waited);
        applyStimulus(16'h5B5B, 16'h7001, 4'd0, waited);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("hold_rst_enable", 32'(enable_decode), 32'd0);
        checkOutput("hold_rst_instr", 32'(instr_dout), 32'd0);
        checkOutput("hold_rst_npc", 32'(npc_in), 32'd0);
        checkOutput("hold_rst_count", 32'(count), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("hold_rst_in_ready", 32'(sif.ready), 32'd1);
        checkOutput("hold_rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("hold_rst_no_residual", 32'(enable_decode), 32'd0);
        end

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
